// File: rtl/zpcl_fetch_ctrl.sv
// Front-end fetch sequencer: owns the fetch PC, issues single-outstanding imem
// requests, arbitrates trap/branch redirects and buffers one instruction for decode.
module zpcl_fetch_ctrl #(
    parameter logic [31:0] START_ADDR = 32'h0000_0000,
    parameter int          STEP       = 4,
    parameter int          CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iStall,
    input  logic             iTrapEn,
    input  logic [31:0]      iTrapPc,
    input  logic             iBjEn,
    input  logic [31:0]      iBjPc,
    output logic             oImemReq,
    output logic [31:0]      oImemAddr,
    input  logic             iImemGnt,
    input  logic             iImemRvld,
    input  logic [31:0]      iImemRdata,
    output logic             oInstVld,
    output logic [31:0]      oInstPc,
    output logic [31:0]      oInst,
    input  logic             iDecRdy,
    output logic             oFlush,
    output logic [1:0]       oRedirSrc,
    output logic [CNT_W-1:0] oDropCnt
);

    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    localparam logic [1:0] SRC_BJ   = 2'd1;
    localparam logic [1:0] SRC_TRAP = 2'd2;

    logic [1:0]       r_state;
    logic [31:0]      r_pc;
    logic [31:0]      r_inflight_pc;
    logic             r_kill;
    logic             r_inst_vld;
    logic [31:0]      r_inst_pc;
    logic [31:0]      r_inst;
    logic             r_flush;
    logic [1:0]       r_redir_src;
    logic [CNT_W-1:0] r_drop_cnt;

    logic             w_redir;
    logic [31:0]      w_target;
    logic [1:0]       w_src;
    logic             w_req;
    logic             w_fire;
    logic             w_rsp;
    logic             w_drop;

    // Trap outranks branch/jump; nothing redirects until BOOT has passed.
    assign w_redir  = (r_state != S_BOOT) & (iTrapEn | iBjEn);
    assign w_target = iTrapEn ? iTrapPc : iBjPc;
    assign w_src    = iTrapEn ? SRC_TRAP : SRC_BJ;

    assign w_req  = (r_state == S_REQ) & ~iStall & ~r_inst_vld;
    assign w_fire = w_req & iImemGnt;
    assign w_rsp  = (r_state == S_WAIT) & iImemRvld;
    assign w_drop = w_rsp & (r_kill | w_redir);

    assign oImemReq  = w_req;
    assign oImemAddr = r_pc;
    assign oInstVld  = r_inst_vld;
    assign oInstPc   = r_inst_pc;
    assign oInst     = r_inst;
    assign oFlush    = r_flush;
    assign oRedirSrc = r_redir_src;
    assign oDropCnt  = r_drop_cnt;

    // NOTE: reset is synchronous, so it lives inside the clocked branch rather
    // than the sensitivity list; all state here uses non-blocking assignments.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= S_BOOT;
            r_pc          <= START_ADDR;
            r_inflight_pc <= '0;
            r_kill        <= 1'b0;
            r_inst_vld    <= 1'b0;
            r_inst_pc     <= '0;
            r_inst        <= '0;
            r_flush       <= 1'b0;
            r_redir_src   <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_flush <= w_redir;
            if (w_redir) begin
                r_redir_src <= w_src;
            end

            if (w_redir) begin
                r_pc <= w_target;
            end else if (w_fire) begin
                r_pc <= r_pc + 32'(STEP);
            end

            // A redirect empties the slot even if decode is taking it this cycle.
            if (w_redir) begin
                r_inst_vld <= 1'b0;
            end else if (w_rsp && !r_kill) begin
                r_inst_vld <= 1'b1;
                r_inst_pc  <= r_inflight_pc;
                r_inst     <= iImemRdata;
            end else if (r_inst_vld && iDecRdy) begin
                r_inst_vld <= 1'b0;
            end

            if (w_drop && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + CNT_W'(1);
            end

            case (r_state)
                S_BOOT: r_state <= S_REQ;
                S_REQ: begin
                    if (w_fire) begin
                        r_state       <= S_WAIT;
                        r_inflight_pc <= r_pc;
                        r_kill        <= w_redir;
                    end
                end
                S_WAIT: begin
                    if (iImemRvld) begin
                        r_state <= S_REQ;
                        r_kill  <= 1'b0;
                    end else if (w_redir) begin
                        r_kill <= 1'b1;
                    end
                end
                default: r_state <= S_BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_zpcl_fetch_ctrl.sv
// Self-checking bench for zpcl_fetch_ctrl: directed scenarios plus a randomized
// run scored against a transaction-level model of the fetch front end.
module tb_zpcl_fetch_ctrl;

    localparam logic [31:0] KEY = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        iStall = 1'b0, iTrapEn = 1'b0, iBjEn = 1'b0;
    logic [31:0] iTrapPc = '0, iBjPc = '0;
    logic        oImemReq;
    logic [31:0] oImemAddr;
    logic        iImemGnt = 1'b0, iImemRvld = 1'b0;
    logic [31:0] iImemRdata = '0;
    logic        oInstVld;
    logic [31:0] oInstPc, oInst;
    logic        iDecRdy = 1'b0;
    logic        oFlush;
    logic [1:0]  oRedirSrc;
    logic [7:0]  oDropCnt;

    always #5 clk = ~clk;

    zpcl_fetch_ctrl #(.START_ADDR(32'h0), .STEP(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .iStall(iStall), .iTrapEn(iTrapEn), .iTrapPc(iTrapPc),
        .iBjEn(iBjEn), .iBjPc(iBjPc), .oImemReq(oImemReq), .oImemAddr(oImemAddr),
        .iImemGnt(iImemGnt), .iImemRvld(iImemRvld), .iImemRdata(iImemRdata),
        .oInstVld(oInstVld), .oInstPc(oInstPc), .oInst(oInst), .iDecRdy(iDecRdy),
        .oFlush(oFlush), .oRedirSrc(oRedirSrc), .oDropCnt(oDropCnt)
    );

    int errors = 0;
    int checks = 0;

    // Stimulus knobs for the next cycle.
    logic        d_gnt, d_stall, d_rdy, d_trap, d_bj;
    logic [31:0] d_trap_pc, d_bj_pc;
    int          d_lat;

    // Memory environment: one pending read, answered after d_lat cycles.
    logic        mem_pend;
    int          mem_cnt;
    logic [31:0] mem_addr;

    // Values sampled during the most recent cycle (before its clock edge).
    logic        s_req, s_gnt, s_rvld, e_req;
    logic [31:0] s_addr, e_addr;

    // Reference model: fetch pointer, one outstanding read, one decode slot.
    logic        m_boot, m_busy, m_busy_kill, m_slot_vld, m_flush;
    logic [31:0] m_pc, m_busy_pc, m_slot_pc, m_slot_inst;
    logic [1:0]  m_src;
    logic [7:0]  m_drops;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        iStall = 0; iTrapEn = 0; iBjEn = 0; iImemGnt = 0; iImemRvld = 0; iDecRdy = 0;
        d_gnt = 0; d_stall = 0; d_rdy = 1; d_trap = 0; d_bj = 0;
        d_trap_pc = '0; d_bj_pc = '0; d_lat = 1;
        mem_pend = 0; mem_cnt = 0; mem_addr = '0;
        m_boot = 1; m_busy = 0; m_busy_kill = 0; m_slot_vld = 0; m_flush = 0;
        m_pc = 32'h0; m_busy_pc = '0; m_slot_pc = '0; m_slot_inst = '0;
        m_src = 2'd0; m_drops = 8'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
    endtask

    // One clock cycle: drive at negedge, sample, advance model, wait to next negedge.
    task automatic step();
        logic        redir, fire, deliver;
        logic [31:0] tgt;
        rst = 1'b1;
        s_rvld     = mem_pend && (mem_cnt == 0);
        iImemRvld  = s_rvld;
        iImemRdata = s_rvld ? (mem_addr ^ KEY) : $urandom;
        iImemGnt = d_gnt; iStall = d_stall; iDecRdy = d_rdy;
        iTrapEn = d_trap; iTrapPc = d_trap_pc; iBjEn = d_bj; iBjPc = d_bj_pc;
        #1;
        s_req  = oImemReq;
        s_addr = oImemAddr;
        s_gnt  = s_req && d_gnt;
        e_req  = !m_boot && !m_busy && !d_stall && !m_slot_vld;
        e_addr = m_pc;

        if (s_rvld) mem_pend = 0;
        else if (mem_pend) mem_cnt--;
        if (s_gnt) begin
            mem_pend = 1; mem_cnt = d_lat - 1; mem_addr = s_addr;
        end

        redir   = !m_boot && (d_trap || d_bj);
        tgt     = d_trap ? d_trap_pc : d_bj_pc;
        fire    = e_req && d_gnt;
        deliver = m_busy && s_rvld;
        if (redir) m_slot_vld = 0;
        else if (deliver && !m_busy_kill) begin
            m_slot_vld = 1; m_slot_pc = m_busy_pc; m_slot_inst = m_busy_pc ^ KEY;
        end else if (m_slot_vld && d_rdy) m_slot_vld = 0;
        if (deliver && (m_busy_kill || redir) && m_drops != 8'hFF) m_drops = m_drops + 8'd1;
        if (fire) begin
            m_busy = 1; m_busy_pc = m_pc; m_busy_kill = redir;
        end else if (deliver) begin
            m_busy = 0; m_busy_kill = 0;
        end else if (m_busy && redir) m_busy_kill = 1;
        if (redir) m_pc = tgt;
        else if (fire) m_pc = m_pc + 32'd4;
        m_flush = redir;
        if (redir) m_src = d_trap ? 2'd2 : 2'd1;
        m_boot = 0;

        @(posedge clk);
        @(negedge clk);
    endtask

    // Advance with grants until pc==addr, then until a request for it is up.
    task automatic run_to_req(input logic [31:0] addr);
        int n = 0;
        d_gnt = 1; d_lat = 1; d_rdy = 1; d_stall = 0;
        while (oImemAddr !== addr && n < 200) begin step(); n++; end
        d_gnt = 0;
        while (oImemReq !== 1'b1 && n < 220) begin step(); n++; end
        checks++;
        if (oImemAddr !== addr || oImemReq !== 1'b1) begin
            errors++;
            $display("FAIL run_to_req: addr=%h req=%b want addr=%h req=1", oImemAddr, oImemReq, addr);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (oImemReq !== 0 || oImemAddr !== 32'h0 || oInstVld !== 0 || oInstPc !== 0 ||
            oInst !== 0 || oFlush !== 0 || oRedirSrc !== 0 || oDropCnt !== 0) begin
            errors++;
            $display("FAIL reset_state: req=%b addr=%h vld=%b ipc=%h inst=%h fl=%b src=%0d drop=%0d want all zero",
                     oImemReq, oImemAddr, oInstVld, oInstPc, oInst, oFlush, oRedirSrc, oDropCnt);
        end
        d_gnt = 1; d_trap = 1; d_trap_pc = 32'h40;
        step();
        checks++;
        if (s_req !== 0 || oFlush !== 0 || oImemAddr !== 32'h0) begin
            errors++;
            $display("FAIL boot_cycle: req=%b flush=%b addr=%h want 0 0 00000000", s_req, oFlush, oImemAddr);
        end
        d_trap = 0; d_gnt = 0;
        step();
        checks++;
        if (s_req !== 1 || s_addr !== 32'h0) begin
            errors++;
            $display("FAIL first_req: req=%b addr=%h want 1 00000000", s_req, s_addr);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] gq[$], pq[$], dq[$];
        logic        flush_seen = 0;
        logic [31:0] exp_a;
        do_reset();
        d_gnt = 1; d_lat = 1; d_rdy = 1;
        for (int c = 0; c < 40; c++) begin
            step();
            if (s_gnt) gq.push_back(s_addr);
            if (oInstVld) begin pq.push_back(oInstPc); dq.push_back(oInst); end
            if (oFlush) flush_seen = 1;
        end
        for (int i = 0; i < 3; i++) begin
            exp_a = 32'(4 * i);
            checks++;
            if (i >= gq.size() || i >= pq.size()) begin
                errors++;
                $display("FAIL seq_count[%0d]: grants=%0d insts=%0d want at least 3", i, gq.size(), pq.size());
            end else if (gq[i] !== exp_a || pq[i] !== exp_a || dq[i] !== (exp_a ^ KEY)) begin
                errors++;
                $display("FAIL seq_item[%0d]: addr=%h pc=%h inst=%h want %h %h %h",
                         i, gq[i], pq[i], dq[i], exp_a, exp_a, exp_a ^ KEY);
            end
        end
        checks++;
        if (flush_seen !== 0) begin
            errors++;
            $display("FAIL seq_flush: flush seen=%b want 0", flush_seen);
        end
    endtask

    task automatic test_bj_in_wait();
        logic [31:0] first_gnt = 32'hDEAD_BEEF;
        int n = 0;
        do_reset();
        run_to_req(32'h10);
        d_gnt = 1; d_lat = 3;
        step();
        d_gnt = 0; d_bj = 1; d_bj_pc = 32'h200;
        step();
        checks++;
        if (oImemAddr !== 32'h200 || oRedirSrc !== 2'd1 || oFlush !== 1) begin
            errors++;
            $display("FAIL bj_redirect: addr=%h src=%0d flush=%b want 00000200 1 1", oImemAddr, oRedirSrc, oFlush);
        end
        d_bj = 0;
        step();
        step();
        checks++;
        if (oDropCnt !== 8'd1 || oInstVld !== 0) begin
            errors++;
            $display("FAIL bj_drop: drop=%0d vld=%b want 1 0", oDropCnt, oInstVld);
        end
        d_gnt = 1; d_lat = 1;
        while (oInstVld !== 1 && n < 10) begin
            step();
            if (s_gnt && first_gnt == 32'hDEAD_BEEF) first_gnt = s_addr;
            n++;
        end
        checks++;
        if (first_gnt !== 32'h200 || oInstVld !== 1 || oInstPc !== 32'h200 || oInst !== (32'h200 ^ KEY)) begin
            errors++;
            $display("FAIL bj_refetch: gnt_addr=%h vld=%b pc=%h inst=%h want 00000200 1 00000200 %h",
                     first_gnt, oInstVld, oInstPc, oInst, 32'h200 ^ KEY);
        end
    endtask

    task automatic test_trap_vs_bj();
        do_reset();
        d_gnt = 1; d_lat = 2;
        repeat (3) step();
        d_trap = 1; d_trap_pc = 32'h80; d_bj = 1; d_bj_pc = 32'h400;
        step();
        checks++;
        if (oImemAddr !== 32'h80 || oRedirSrc !== 2'd2 || oFlush !== 1) begin
            errors++;
            $display("FAIL trap_wins: addr=%h src=%0d flush=%b want 00000080 2 1", oImemAddr, oRedirSrc, oFlush);
        end
        d_trap = 0; d_bj = 0;
        step();
        checks++;
        if (oFlush !== 0 || oRedirSrc !== 2'd2) begin
            errors++;
            $display("FAIL flush_pulse: flush=%b src=%0d want 0 2", oFlush, oRedirSrc);
        end
    endtask

    task automatic test_redir_with_gnt();
        logic [7:0]  d0;
        logic [31:0] first_gnt = 32'hDEAD_BEEF, first_pc = 32'hDEAD_BEEF;
        logic        bad_seen = 0;
        do_reset();
        run_to_req(32'h20);
        d0 = m_drops;
        d_gnt = 1; d_lat = 1; d_bj = 1; d_bj_pc = 32'h300;
        step();
        checks++;
        if (s_gnt !== 1 || oImemAddr !== 32'h300) begin
            errors++;
            $display("FAIL redir_gnt_pc: gnt=%b addr=%h want 1 00000300", s_gnt, oImemAddr);
        end
        d_bj = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (s_gnt && first_gnt == 32'hDEAD_BEEF) first_gnt = s_addr;
            if (s_gnt && s_addr == 32'h24) bad_seen = 1;
            if (oInstVld && first_pc == 32'hDEAD_BEEF) first_pc = oInstPc;
        end
        checks++;
        if (first_gnt !== 32'h300 || first_pc !== 32'h300 || bad_seen !== 0 || oDropCnt !== d0 + 8'd1) begin
            errors++;
            $display("FAIL redir_gnt_kill: gnt=%h pc=%h saw24=%b drop=%0d want 00000300 00000300 0 %0d",
                     first_gnt, first_pc, bad_seen, oDropCnt, d0 + 8'd1);
        end
    endtask

    task automatic test_stall();
        logic [31:0] a0;
        int n = 0;
        do_reset();
        step();
        d_gnt = 1; d_lat = 1; d_rdy = 0;
        while (oInstVld !== 1 && n < 20) begin step(); n++; end
        for (int c = 0; c < 4; c++) begin
            step();
            checks++;
            if (s_req !== 0 || oInstVld !== 1) begin
                errors++;
                $display("FAIL slot_full_blocks[%0d]: req=%b vld=%b want 0 1", c, s_req, oInstVld);
            end
        end
        d_rdy = 1; d_stall = 1;
        a0 = oImemAddr;
        checks++;
        if (a0 !== 32'h4) begin
            errors++;
            $display("FAIL stall_pc: addr=%h want 00000004", a0);
        end
        for (int c = 0; c < 4; c++) begin
            step();
            checks++;
            if (s_req !== 0 || oImemAddr !== a0 || oInstVld !== 0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: req=%b addr=%h vld=%b want 0 %h 0", c, s_req, oImemAddr, oInstVld, a0);
            end
        end
        d_bj = 1; d_bj_pc = 32'h500;
        step();
        d_bj = 0;
        step();
        checks++;
        if (oImemAddr !== 32'h500 || s_req !== 0) begin
            errors++;
            $display("FAIL stall_redirect: addr=%h req=%b want 00000500 0", oImemAddr, s_req);
        end
        d_stall = 0;
        step();
        checks++;
        if (s_req !== 1 || s_addr !== 32'h500) begin
            errors++;
            $display("FAIL stall_release: req=%b addr=%h want 1 00000500", s_req, s_addr);
        end
    endtask

    task automatic test_drop_sat_and_wrap();
        int n = 0;
        do_reset();
        step();
        d_gnt = 1; d_lat = 1; d_bj = 1; d_bj_pc = 32'h1000;
        repeat (100) step();
        checks++;
        if (oDropCnt !== 8'd50) begin
            errors++;
            $display("FAIL drop_count_mid: drop=%0d want 50", oDropCnt);
        end
        repeat (418) step();
        checks++;
        if (oDropCnt !== 8'hFF) begin
            errors++;
            $display("FAIL drop_saturate: drop=%0d want 255", oDropCnt);
        end
        do_reset();
        step();
        d_gnt = 0; d_bj = 1; d_bj_pc = 32'hFFFF_FFFC;
        step();
        d_bj = 0; d_gnt = 1; d_lat = 1;
        step();
        checks++;
        if (s_gnt !== 1 || s_addr !== 32'hFFFF_FFFC || oImemAddr !== 32'h0) begin
            errors++;
            $display("FAIL pc_wrap: gnt=%b addr=%h next=%h want 1 fffffffc 00000000", s_gnt, s_addr, oImemAddr);
        end
        while (oInstVld !== 1 && n < 10) begin step(); n++; end
        checks++;
        if (oInstVld !== 1 || oInstPc !== 32'hFFFF_FFFC || oInst !== (32'hFFFF_FFFC ^ KEY)) begin
            errors++;
            $display("FAIL wrap_inst: vld=%b pc=%h inst=%h want 1 fffffffc %h", oInstVld, oInstPc, oInst, 32'hFFFF_FFFC ^ KEY);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            d_gnt   = ($urandom_range(0, 3) != 0);
            d_stall = ($urandom_range(0, 4) == 0);
            d_rdy   = ($urandom_range(0, 3) != 0);
            d_trap  = ($urandom_range(0, 24) == 0);
            d_bj    = ($urandom_range(0, 9) == 0);
            d_trap_pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'h0000_FFFC);
            d_bj_pc   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h000F_FFFC);
            d_lat   = $urandom_range(1, 4);
            step();
            checks++;
            if (s_req !== e_req || s_addr !== e_addr) begin
                errors++;
                $display("FAIL rnd_req[%0d]: req=%b addr=%h want %b %h", c, s_req, s_addr, e_req, e_addr);
            end
            checks++;
            if (oInstVld !== m_slot_vld || (m_slot_vld && (oInstPc !== m_slot_pc || oInst !== m_slot_inst))) begin
                errors++;
                $display("FAIL rnd_slot[%0d]: vld=%b pc=%h inst=%h want %b %h %h",
                         c, oInstVld, oInstPc, oInst, m_slot_vld, m_slot_pc, m_slot_inst);
            end
            checks++;
            if (oFlush !== m_flush || oRedirSrc !== m_src || oDropCnt !== m_drops) begin
                errors++;
                $display("FAIL rnd_status[%0d]: flush=%b src=%0d drop=%0d want %b %0d %0d",
                         c, oFlush, oRedirSrc, oDropCnt, m_flush, m_src, m_drops);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_bj_in_wait();
        test_trap_vs_bj();
        test_redir_with_gnt();
        test_stall();
        test_drop_sat_and_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
